// File: rtl/pn_pkg.sv
// Shared encodings for the Polish Notation token interface: operator and mode
// codes, transmitter FSM states, token field selectors and the burst length rule.
package pn_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_ABS = 2'd3;

  localparam logic [1:0] PRE3   = 2'd0;
  localparam logic [1:0] POST3  = 2'd1;
  localparam logic [1:0] PRECH  = 2'd2;
  localparam logic [1:0] POSTCH = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_e;

  typedef enum logic [1:0] {
    F_OP,
    F_A,
    F_B
  } field_e;

  // Triples carry three tokens per operator; chains share one running operand.
  function automatic int len(input logic [1:0] mode, input int n);
    return mode[1] ? 2 * n + 1 : 3 * n;
  endfunction

endpackage

// File: rtl/pn_token_sel.sv
// Combinational token picker: which field (operator, a or b) and which lane
// is sent at token index k for the given mode and operator count.
module pn_token_sel
  import pn_pkg::*;
#(
  parameter int MAX_EXPR = 4,
  parameter int TW       = 4
) (
  input  logic [1:0]            mode,
  input  logic [2:0]            n,
  input  logic [TW-1:0]         k,
  input  logic [2*MAX_EXPR-1:0] ops,
  input  logic [3*MAX_EXPR-1:0] a,
  input  logic [3*MAX_EXPR-1:0] b,
  output logic                  operator,
  output logic [2:0]            val
);

  field_e fld;
  int     ki;
  int     nn;
  int     lane;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ki   = int'(k);
    nn   = int'(n);
    fld  = F_OP;
    lane = 0;
    case (mode)
      PRE3: begin
        lane = ki / 3;
        case (ki % 3)
          0:       fld = F_OP;
          1:       fld = F_A;
          default: fld = F_B;
        endcase
      end
      POST3: begin
        lane = ki / 3;
        case (ki % 3)
          0:       fld = F_A;
          1:       fld = F_B;
          default: fld = F_OP;
        endcase
      end
      PRECH: begin
        // Outermost operator first, then the seed operand and the chain operands.
        if (ki < nn) begin
          fld  = F_OP;
          lane = nn - 1 - ki;
        end else if (ki == nn) begin
          fld  = F_A;
          lane = 0;
        end else begin
          fld  = F_B;
          lane = ki - nn - 1;
        end
      end
      default: begin
        if (ki == 0) begin
          fld  = F_A;
          lane = 0;
        end else if (ki[0]) begin
          fld  = F_B;
          lane = (ki - 1) / 2;
        end else begin
          fld  = F_OP;
          lane = (ki - 2) / 2;
        end
      end
    endcase
  end

  always_comb begin
    operator = (fld == F_OP);
    case (fld)
      F_OP:    val = {1'b0, 2'(ops >> (2 * lane))};
      F_A:     val = 3'(a >> (3 * lane));
      default: val = 3'(b >> (3 * lane));
    endcase
  end

endmodule

// File: rtl/pn_token_tx.sv
// Serializes one PN expression command into the evaluator token stream, then
// collects and counts the evaluator responses and reports done/err/timeout.
module pn_token_tx
  import pn_pkg::*;
#(
  parameter int MAX_EXPR   = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [2:0]            cmd_cnt,
  input  logic [2*MAX_EXPR-1:0] cmd_ops,
  input  logic [3*MAX_EXPR-1:0] cmd_a,
  input  logic [3*MAX_EXPR-1:0] cmd_b,
  output logic                  pn_in_valid,
  output logic [1:0]            pn_mode,
  output logic                  pn_operator,
  output logic [2:0]            pn_in,
  input  logic                  pn_out_valid,
  input  logic [31:0]           pn_out,
  output logic                  done,
  output logic                  err,
  output logic                  timeout,
  output logic [2:0]            rsp_cnt,
  output logic [31:0]           last_rsp
);

  localparam int TW = $clog2(3 * MAX_EXPR + 1);
  localparam int MW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e                state;
  logic [TW-1:0]         tok_idx;
  logic [MW-1:0]         tmo;
  logic [GW-1:0]         gap_cnt;

  logic [1:0]            mode_q;
  logic [2:0]            n_q;
  logic [2*MAX_EXPR-1:0] ops_q;
  logic [3*MAX_EXPR-1:0] a_q;
  logic [3*MAX_EXPR-1:0] b_q;

  logic [1:0]            sel_mode;
  logic [2:0]            sel_n;
  logic [TW-1:0]         sel_k;
  logic [2*MAX_EXPR-1:0] sel_ops;
  logic [3*MAX_EXPR-1:0] sel_a;
  logic [3*MAX_EXPR-1:0] sel_b;
  logic                  sel_operator;
  logic [2:0]            sel_val;

  logic                  accept;
  logic                  cnt_bad;
  logic [TW-1:0]         tok_last;
  logic [2:0]            rsp_exp;

  assign accept   = cmd_valid && cmd_ready;
  assign cnt_bad  = (cmd_cnt == 3'd0) || (int'(cmd_cnt) > MAX_EXPR);
  assign tok_last = TW'(len(mode_q, int'(n_q)) - 1);
  assign rsp_exp  = mode_q[1] ? 3'd1 : n_q;

  // In IDLE the picker looks at the live command so token 0 registers on accept.
  always_comb begin
    if (state == S_IDLE) begin
      sel_mode = cmd_mode;
      sel_n    = cmd_cnt;
      sel_k    = '0;
      sel_ops  = cmd_ops;
      sel_a    = cmd_a;
      sel_b    = cmd_b;
    end else begin
      sel_mode = mode_q;
      sel_n    = n_q;
      sel_k    = tok_idx + TW'(1);
      sel_ops  = ops_q;
      sel_a    = a_q;
      sel_b    = b_q;
    end
  end

  pn_token_sel #(
    .MAX_EXPR (MAX_EXPR),
    .TW       (TW)
  ) u_sel (
    .mode     (sel_mode),
    .n        (sel_n),
    .k        (sel_k),
    .ops      (sel_ops),
    .a        (sel_a),
    .b        (sel_b),
    .operator (sel_operator),
    .val      (sel_val)
  );

  // NOTE: the command holding registers are pure datapath, only read after a
  // load, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_q <= cmd_mode;
      n_q    <= cmd_cnt;
      ops_q  <= cmd_ops;
      a_q    <= cmd_a;
      b_q    <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      pn_in_valid <= 1'b0;
      pn_mode     <= 2'd0;
      pn_operator <= 1'b0;
      pn_in       <= 3'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      timeout     <= 1'b0;
      rsp_cnt     <= 3'd0;
      last_rsp    <= 32'd0;
      tok_idx     <= '0;
      tmo         <= '0;
      gap_cnt     <= '0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments
      // in the same edge, giving single-cycle pulses without extra logic.
      done    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            rsp_cnt   <= 3'd0;
            last_rsp  <= 32'd0;
            tok_idx   <= '0;
            if (cnt_bad) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state       <= S_SEND;
              pn_in_valid <= 1'b1;
              pn_mode     <= cmd_mode;
              pn_operator <= sel_operator;
              pn_in       <= sel_val;
            end
          end
        end
        S_SEND: begin
          if (tok_idx == tok_last) begin
            state       <= S_WAIT;
            pn_in_valid <= 1'b0;
            pn_mode     <= 2'd0;
            pn_operator <= 1'b0;
            pn_in       <= 3'd0;
            tmo         <= '0;
          end else begin
            tok_idx     <= tok_idx + TW'(1);
            pn_operator <= sel_operator;
            pn_in       <= sel_val;
          end
        end
        S_WAIT: begin
          if (pn_out_valid) begin
            rsp_cnt  <= rsp_cnt + 3'd1;
            last_rsp <= pn_out;
            tmo      <= '0;
            if (rsp_cnt + 3'd1 == rsp_exp) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else if (tmo == MW'(TIMEOUT - 1)) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            tmo <= tmo + MW'(1);
          end
        end
        S_DONE: begin
          gap_cnt <= '0;
          if (GAP_CYCLES == 0) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
